// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory responder.
// Big-endian byte lanes: byte offset 0 is bits 31:24.
package mem_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Alignment only; the illegal size encoding is flagged separately.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SIZE_WORD) && (offset != 2'b00)) ||
               ((size == SIZE_HALF) && offset[0]);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts a word, halfword or byte from a big-endian memory word and
// zero- or sign-extends it to 32 bits.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;
    logic [15:0] halfVal;
    logic [7:0]  byteVal;

    // Shifting the addressed lane to the top makes every size read bits 31 and down.
    assign shifted = word_i << {offset_i, 3'b000};
    assign halfVal = shifted[31:16];
    assign byteVal = shifted[31:24];

    always_comb begin
        result_o = word_i;
        case (size_i)
            SIZE_HALF: result_o = {{16{signed_i & halfVal[15]}}, halfVal};
            SIZE_BYTE: result_o = {{24{signed_i & byteVal[7]}}, byteVal};
            default:   result_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency on-chip data memory answering MEM-stage loads and stores,
// stalling the pipeline with Busy until the one-cycle Done pulse.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        LoadSigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Busy,
    output logic        Done,
    output logic        MemErr
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] readData_q, readData_d;
    logic        memErr_q, memErr_d;

    logic        read_q, write_q, signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, writeData_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             request, doAccess, memWe;
    logic             accRead, accWrite, accSigned, accErr;
    logic [1:0]       accSize;
    logic [31:0]      accAddr, accWData, oldWord, mergedWord, alignedData;
    logic [IDX_W-1:0] accIdx;
    logic             unusedAddrBits;

    assign request = MemRead | MemWrite;

    // With LATENCY=1 the access happens on the accept edge, before the latches hold anything.
    assign accRead   = (state_q == IDLE) ? MemRead    : read_q;
    assign accWrite  = (state_q == IDLE) ? MemWrite   : write_q;
    assign accSize   = (state_q == IDLE) ? MemSize    : size_q;
    assign accSigned = (state_q == IDLE) ? LoadSigned : signed_q;
    assign accAddr   = (state_q == IDLE) ? Address    : addr_q;
    assign accWData  = (state_q == IDLE) ? WriteData  : writeData_q;

    assign accIdx         = accAddr[IDX_W+1:2];
    assign unusedAddrBits = ^accAddr[31:IDX_W+2];
    assign oldWord        = mem_q[accIdx];
    assign accErr         = (accRead & accWrite) | (accSize == 2'b11) |
                            isMisaligned(accSize, accAddr[1:0]);

    mem_load_align u_loadAlign (
        .word_i   (oldWord),
        .offset_i (accAddr[1:0]),
        .size_i   (accSize),
        .signed_i (accSigned),
        .result_o (alignedData)
    );

    always_comb begin
        mergedWord = oldWord;
        case (accSize)
            SIZE_WORD: mergedWord = accWData;
            SIZE_HALF: begin
                if (accAddr[1]) mergedWord[15:0]  = accWData[15:0];
                else            mergedWord[31:16] = accWData[15:0];
            end
            SIZE_BYTE: begin
                case (accAddr[1:0])
                    2'd0:    mergedWord[31:24] = accWData[7:0];
                    2'd1:    mergedWord[23:16] = accWData[7:0];
                    2'd2:    mergedWord[15:8]  = accWData[7:0];
                    default: mergedWord[7:0]   = accWData[7:0];
                endcase
            end
            default: mergedWord = oldWord;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        readData_d = readData_q;
        memErr_d   = memErr_q;
        doAccess   = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (request) begin
                    Busy = 1'b1;
                    if (CNT_INIT == 4'd0) begin
                        doAccess = 1'b1;
                        state_d  = RESP;
                    end else begin
                        count_d = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                Busy = 1'b1;
                if (count_q <= 4'd1) begin
                    doAccess = 1'b1;
                    count_d  = 4'd0;
                    state_d  = RESP;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESP: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (doAccess) begin
            readData_d = accErr ? 32'd0 : alignedData;
            memErr_d   = accErr;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            count_q    <= 4'd0;
            readData_q <= 32'd0;
            memErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            readData_q <= readData_d;
            memErr_q   <= memErr_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (state_q == IDLE && request) begin
            read_q      <= MemRead;
            write_q     <= MemWrite;
            size_q      <= MemSize;
            signed_q    <= LoadSigned;
            addr_q      <= Address;
            writeData_q <= WriteData;
        end
    end

    // A reset on the commit edge abandons the store.
    assign memWe = doAccess & accWrite & ~accErr & ~Rst;

    always_ff @(posedge Clk) begin
        if (memWe) mem_q[accIdx] <= mergedWord;
    end

    assign ReadData = readData_q;
    assign MemErr   = memErr_q & Done;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder, checked through a
// byte-addressed reference memory and an expected-response queue.
module tb_data_mem_responder;

    localparam int LATENCY = 2;

    logic        Clk = 1'b0;
    logic        Rst, MemRead, MemWrite, LoadSigned;
    logic [1:0]  MemSize;
    logic [31:0] Address, WriteData, ReadData;
    logic        Busy, Done, MemErr;

    always #5 Clk = ~Clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LATENCY)) dut (
        .Clk(Clk), .Rst(Rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .LoadSigned(LoadSigned), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData), .Busy(Busy),
        .Done(Done), .MemErr(MemErr)
    );

    typedef struct {
        logic        err;
        logic        checkData;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t       expQ[$];
    int         checkCount = 0;
    int         failCount  = 0;
    int         doneCount  = 0;
    logic [7:0] refMem [4096];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic refError(input logic rd, input logic wr, input logic [1:0] size, input logic [31:0] addr);
        return (rd && wr) || (size == 2'b11) ||
               (size == 2'b00 && addr[1:0] != 2'b00) || (size == 2'b01 && addr[0]);
    endfunction

    function automatic logic [31:0] refLoad(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
        int a;
        logic [15:0] h;
        logic [7:0]  b;
        a = int'(addr & 32'hFFF);
        if (size == 2'b00)
            return {refMem[a], refMem[a+1], refMem[a+2], refMem[a+3]};
        if (size == 2'b01) begin
            h = {refMem[a], refMem[a+1]};
            return (sgn && h[15]) ? {16'hFFFF, h} : {16'h0000, h};
        end
        b = refMem[a];
        return (sgn && b[7]) ? {24'hFFFFFF, b} : {24'h000000, b};
    endfunction

    task automatic refStore(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int a;
        a = int'(addr & 32'hFFF);
        if (size == 2'b00) begin
            refMem[a]   = wdata[31:24];
            refMem[a+1] = wdata[23:16];
            refMem[a+2] = wdata[15:8];
            refMem[a+3] = wdata[7:0];
        end else if (size == 2'b01) begin
            refMem[a]   = wdata[15:8];
            refMem[a+1] = wdata[7:0];
        end else begin
            refMem[a] = wdata[7:0];
        end
    endtask

    // Called 1 time unit after a rising edge; leaves the request held through RESP.
    task automatic applyStimulus(input string name, input logic rd, input logic wr, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   cycles;
        MemRead    = rd;
        MemWrite   = wr;
        MemSize    = size;
        LoadSigned = sgn;
        Address    = addr;
        WriteData  = wdata;
        e.name      = name;
        e.err       = refError(rd, wr, size, addr);
        e.checkData = e.err || rd;
        e.data      = (e.err || !rd) ? 32'd0 : refLoad(size, sgn, addr);
        expQ.push_back(e);
        if (!e.err && wr) refStore(size, addr, wdata);
        cycles = 0;
        while (1) begin
            @(negedge Clk);
            cycles++;
            if (Done) break;
            checkOutput({name, " busy"}, 32'(Busy), 32'd1);
            if (cycles > 20) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL %s timeout: no Done after %0d cycles, required %0d", name, cycles, LATENCY + 1);
                break;
            end
        end
        if (Done) begin
            checkOutput({name, " latency"}, 32'(cycles), 32'(LATENCY + 1));
            checkOutput({name, " busy in resp"}, 32'(Busy), 32'd0);
        end
        @(posedge Clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (!Rst && Done) begin
            doneCount++;
            if (expQ.size() == 0) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL unexpected done: got Done=1, required no pending request");
            end else begin
                e = expQ.pop_front();
                checkOutput({e.name, " err"}, 32'(MemErr), 32'(e.err));
                if (e.checkData) checkOutput({e.name, " data"}, ReadData, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        logic [1:0]  rSize;
        logic [31:0] rAddr;
        int          op;

        Rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00;
        LoadSigned = 1'b0; Address = 32'd0; WriteData = 32'd0;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("reset ReadData", ReadData, 32'd0);
        checkOutput("reset Busy", 32'(Busy), 32'd0);
        checkOutput("reset Done", 32'(Done), 32'd0);
        checkOutput("reset MemErr", 32'(MemErr), 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        $display("[TB] word store and load");
        applyStimulus("sw10", 1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);
        applyStimulus("lw10", 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);

        $display("[TB] byte merge and extension");
        applyStimulus("sb13",  1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h000000A5);
        applyStimulus("lw10b", 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        applyStimulus("lb13",  1'b1, 1'b0, 2'b10, 1'b1, 32'h13, 32'h0);
        applyStimulus("lbu13", 1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        applyStimulus("lhu10", 1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);

        $display("[TB] misalignment and illegal requests");
        applyStimulus("lh11",   1'b1, 1'b0, 2'b01, 1'b1, 32'h11, 32'h0);
        applyStimulus("sw12",   1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h11111111);
        applyStimulus("lw10c",  1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        applyStimulus("rdwr",   1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0);
        applyStimulus("lw10d",  1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        applyStimulus("size11", 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);

        $display("[TB] reset during an in-flight store");
        applyStimulus("sw20pre", 1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'hCAFEF00D);
        MemWrite = 1'b1; MemRead = 1'b0; MemSize = 2'b00;
        Address = 32'h20; WriteData = 32'h12345678;
        @(negedge Clk);
        checkOutput("abort busy", 32'(Busy), 32'd1);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        MemWrite = 1'b0;
        @(negedge Clk);
        checkOutput("abort busy after", 32'(Busy), 32'd0);
        checkOutput("abort done after", 32'(Done), 32'd0);
        @(posedge Clk);
        #1;
        applyStimulus("lw20", 1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);

        $display("[TB] back-to-back requests");
        d0 = doneCount;
        applyStimulus("b2b1", 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        applyStimulus("b2b2", 1'b1, 1'b0, 2'b10, 1'b1, 32'h12, 32'h0);
        repeat (6) @(negedge Clk);
        checkOutput("b2b done pulses", 32'(doneCount - d0), 32'd2);
        @(posedge Clk);
        #1;

        $display("[TB] randomized accesses");
        for (int i = 0; i < 16; i++)
            applyStimulus("preload", 1'b0, 1'b1, 2'b00, 1'b0, 32'h100 + 32'(4 * i), $urandom);
        for (int i = 0; i < 60; i++) begin
            op    = int'($urandom_range(0, 9));
            rSize = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rAddr = (32'h100 + 32'($urandom_range(0, 63))) |
                    (($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFFF000) : 32'd0);
            applyStimulus($sformatf("rand%0d", i), (op < 5) || (op == 9), op >= 5, rSize,
                          1'($urandom_range(0, 1)), rAddr, $urandom);
        end

        repeat (4) @(negedge Clk);
        checkOutput("pending responses", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
